// File: rtl/div_sequencer.sv
// Run controller for the modulo divider: programmable terminal count, burst of
// fout strobes, abort, completion and start-rejection reporting.
module div_sequencer #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned BURST_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   div_n,
    input  logic [BURST_W-1:0] burst,
    output logic [WIDTH-1:0]   count,
    output logic [BURST_W-1:0] pulses,
    output logic               fout,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   n_q;
    logic [WIDTH-1:0]   n_nx;
    logic [WIDTH-1:0]   count_nx;
    logic [WIDTH-1:0]   last;
    logic [BURST_W-1:0] b_q;
    logic [BURST_W-1:0] b_nx;
    logic [BURST_W-1:0] pulses_nx;
    logic [BURST_W-1:0] pulses_inc;
    logic               start_ok;
    logic               start_bad;
    logic               wrap;
    logic               final_wrap;
    logic               fout_nx;
    logic               busy_nx;
    logic               done_nx;
    logic               err_nx;

    // Run qualifiers derived from registered state and the latched configuration
    always_comb begin
        start_ok   = (state == S_IDLE) && start && (div_n >= WIDTH'(2));
        start_bad  = (state == S_IDLE) && start && (div_n <  WIDTH'(2));
        last       = n_q - WIDTH'(1);
        wrap       = (state == S_RUN) && (count == last);
        pulses_inc = pulses + BURST_W'(1);
        final_wrap = wrap && (b_q != BURST_W'(0)) && (pulses_inc == b_q);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; abort takes priority over a coincident final wrap
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start_ok) state_nx = S_RUN;
            S_RUN: begin
                if (abort)           state_nx = S_IDLE;
                else if (final_wrap) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        n_nx      = n_q;
        b_nx      = b_q;
        count_nx  = count;
        pulses_nx = pulses;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    n_nx      = div_n;
                    b_nx      = burst;
                    count_nx  = WIDTH'(0);
                    pulses_nx = BURST_W'(0);
                end
            end
            S_RUN: begin
                if (abort) begin
                    count_nx = WIDTH'(0);
                end else if (wrap) begin
                    count_nx  = WIDTH'(0);
                    pulses_nx = pulses_inc;
                end else begin
                    count_nx = count + WIDTH'(1);
                end
            end
            S_DONE:  count_nx = WIDTH'(0);
            default: count_nx = WIDTH'(0);
        endcase
        fout_nx = (state_nx == S_RUN) && (count_nx == (n_nx - WIDTH'(1)));
        busy_nx = (state_nx != S_IDLE);
        done_nx = (state_nx == S_DONE);
        err_nx  = start_bad;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_q    <= WIDTH'(0);
            b_q    <= BURST_W'(0);
            count  <= WIDTH'(0);
            pulses <= BURST_W'(0);
            fout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            n_q    <= n_nx;
            b_q    <= b_nx;
            count  <= count_nx;
            pulses <= pulses_nx;
            fout   <= fout_nx;
            busy   <= busy_nx;
            done   <= done_nx;
            err    <= err_nx;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: free run, burst, rejection, abort and
// asynchronous reset, with expectations computed from the cycle index.
module tb_div_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [2:0] div_n;
    logic [3:0] burst;
    logic [2:0] count;
    logic [3:0] pulses;
    logic       fout;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    div_sequencer #(.WIDTH(3), .BURST_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .abort  (abort),
        .div_n  (div_n),
        .burst  (burst),
        .count  (count),
        .pulses (pulses),
        .fout   (fout),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_fout"},  32'(fout),  0);
        check({tag, "_busy"},  32'(busy),  0);
        check({tag, "_done"},  32'(done),  0);
        check({tag, "_err"},   32'(err),   0);
    endtask

    initial begin
        int nf;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        div_n = 3'd0;
        burst = 4'd0;
        #3;
        check_idle_outputs("rst");
        check("rst_pulses", 32'(pulses), 0);
        #9 reset = 1'b1;
        tick();
        check_idle_outputs("rel");

        // Free run N=5, B=0 through a pulse-counter wrap, stopped by abort
        div_n = 3'd5; burst = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 84; k++) begin
            check("t1_count",  32'(count),  k % 5);
            check("t1_fout",   32'(fout),   32'((k % 5) == 4));
            check("t1_pulses", 32'(pulses), (k / 5) % 16);
            check("t1_busy",   32'(busy),   1);
            if (k < 84) tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle_outputs("t1_abort");

        // Burst N=3, B=4
        div_n = 3'd3; burst = 4'd4; start = 1'b1;
        tick();
        start = 1'b0;
        nf = 0;
        for (int k = 0; k <= 14; k++) begin
            check("t2_count",  32'(count),  (k < 12) ? (k % 3) : 0);
            check("t2_fout",   32'(fout),   32'((k < 12) && ((k % 3) == 2)));
            check("t2_done",   32'(done),   32'(k == 12));
            check("t2_busy",   32'(busy),   32'(k <= 12));
            check("t2_pulses", 32'(pulses), (k < 12) ? (k / 3) : 4);
            if (fout) nf++;
            if (k < 14) tick();
        end
        check("t2_fout_cnt", 32'(nf), 4);

        // Rejected starts with N=1 and N=0
        for (int v = 1; v >= 0; v--) begin
            div_n = 3'(v); start = 1'b1;
            tick();
            start = 1'b0;
            check("t3_err",    32'(err),    1);
            check("t3_busy",   32'(busy),   0);
            check("t3_count",  32'(count),  0);
            check("t3_pulses", 32'(pulses), 4);
            tick();
            check("t3_err_off", 32'(err),  0);
            check("t3_busy2",   32'(busy), 0);
        end

        // N=7, B=2, ignored restart, abort at count 3 of second period
        div_n = 3'd7; burst = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            check("t4_count",  32'(count),  k % 7);
            check("t4_fout",   32'(fout),   32'((k % 7) == 6));
            check("t4_pulses", 32'(pulses), k / 7);
            check("t4_busy",   32'(busy),   1);
            check("t4_err",    32'(err),    0);
            if (k == 4) begin
                start = 1'b1; div_n = 3'd2; burst = 4'd1;
            end else begin
                start = 1'b0;
            end
            if (k == 10) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        check_idle_outputs("t4_abort");
        check("t4_pulses_hold", 32'(pulses), 1);
        tick();
        check("t4_done_after", 32'(done), 0);
        check("t4_busy_after", 32'(busy), 0);

        // N=4, B=1, abort coincident with the final fout
        div_n = 3'd4; burst = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        nf = 0;
        for (int k = 0; k <= 3; k++) begin
            check("t5_count", 32'(count), k);
            if (fout) nf++;
            if (k == 3) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        if (fout) nf++;
        check("t5_fout_cnt", 32'(nf), 1);
        check_idle_outputs("t5_abort");
        check("t5_pulses", 32'(pulses), 0);
        tick();
        check("t5_done_after", 32'(done), 0);
        check("t5_busy_after", 32'(busy), 0);

        // Asynchronous reset mid-run with N=6
        div_n = 3'd6; burst = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("t6_count_pre", 32'(count), 3);
        #3 reset = 1'b0;
        #1;
        check_idle_outputs("t6_async");
        check("t6_pulses", 32'(pulses), 0);
        @(posedge clk);
        #4 reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t6_quiet_busy",  32'(busy),  0);
            check("t6_quiet_count", 32'(count), 0);
            check("t6_quiet_fout",  32'(fout),  0);
        end
        div_n = 3'd2; burst = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_restart_busy",  32'(busy),  1);
        check("t6_restart_count", 32'(count), 0);
        tick();
        check("t6_restart_count1", 32'(count), 1);
        check("t6_restart_fout",   32'(fout),  1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
